alu_sequencer: RTL and testbench

- Multi-cycle controller directly upstream of the datapath ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and holds an internal register bank.
- Drives the ALU's `ins`/`a_in`/`b_in` inputs and writes the combinational `alu_out` result back to the bank.
- Implements LOAD, ADD, XOR and MIN, plus the iterative MINALL reduction, which walks every register through the ALU's MIN path.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_regbank.sv | 37 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, instruction fields and FSM states for the ALU sequencer.
// ALU_SEQ_MINALL_EN enables the MINALL reduction and its LOOP state.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_MIN    = 4'b0100;
  localparam logic [3:0] OP_MINALL = 4'b0111;

  localparam int OP_LSB = 12;
  localparam int RX_LSB = 8;
  localparam int RY_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_SEQ_MINALL_EN
    , S_LOOP = 2'd3
`endif
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LOAD, OP_ADD, OP_XOR, OP_MIN: return 1'b1;
`ifdef ALU_SEQ_MINALL_EN
      OP_MINALL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regbank.sv
// NREG x 16 register bank: two comb read ports, a debug read port,
// one synchronous write port, async active-low clear.
module alu_regbank #(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_sel,
  output logic [15:0]   ra_data,
  input  logic [AW-1:0] rb_sel,
  output logic [15:0]   rb_data,
  input  logic [3:0]    dbg_sel,
  output logic [15:0]   dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wsel,
  input  logic [15:0]   wdata
);

  logic [15:0] regs [NREG];
  logic        unused_dbg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  // upper select bits beyond the bank size are ignored
  assign dbg_data = regs[dbg_sel[AW-1:0]];
  assign unused_dbg = ^dbg_sel;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller driving an external ALU and a register bank.
// ALU_SEQ_MINALL_EN adds the MINALL reduction (LOOP state, acc, idx).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic [15:0] data_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  ins,
  output logic [15:0] a_in,
  output logic [15:0] b_in,
  input  logic [15:0] alu_out,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam int AW = $clog2(NREG);

  state_t        state;
  logic [3:0]    op_q;
  logic [AW-1:0] rx_q;
  logic [AW-1:0] ry_q;

  logic [3:0]    op_in;
  logic [AW-1:0] rx_in;
  logic [AW-1:0] ry_in;
  logic          accept;
  logic          unused_instr;

  logic [AW-1:0] ra_sel;
  logic [AW-1:0] rb_sel;
  logic [AW-1:0] wsel;
  logic [15:0]   ra_data;
  logic [15:0]   rb_data;
  logic [15:0]   wdata;
  logic          we;

`ifdef ALU_SEQ_MINALL_EN
  logic [15:0]   acc;
  logic [AW-1:0] idx;
`endif

  assign op_in        = instr[OP_LSB +: 4];
  assign rx_in        = instr[RX_LSB +: AW];
  assign ry_in        = instr[RY_LSB +: AW];
  assign instr_ready  = state == S_IDLE;
  assign accept       = instr_valid && instr_ready;
  assign unused_instr = ^instr;

  alu_regbank #(
    .NREG (NREG),
    .AW   (AW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_sel   (ra_sel),
    .ra_data  (ra_data),
    .rb_sel   (rb_sel),
    .rb_data  (rb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata)
  );

  always_comb begin
    ins    = OP_NOP;
    a_in   = '0;
    b_in   = '0;
    ra_sel = rx_q;
    rb_sel = ry_q;
    we     = 1'b0;
    wsel   = rx_q;
    wdata  = alu_out;
    unique case (state)
      S_IDLE: begin
        // port A reads R[0] so MINALL can seed acc on accept
        ra_sel = '0;
        if (accept && op_in == OP_LOAD) begin
          we    = 1'b1;
          wsel  = rx_in;
          wdata = data_in;
        end
      end
      S_EXEC: begin
        ins  = op_q;
        a_in = ra_data;
        b_in = rb_data;
        we   = 1'b1;
      end
`ifdef ALU_SEQ_MINALL_EN
      S_LOOP: begin
        ins    = OP_MINALL;
        a_in   = acc;
        rb_sel = idx;
        b_in   = rb_data;
        we     = idx == '1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_NOP;
      rx_q   <= '0;
      ry_q   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
`ifdef ALU_SEQ_MINALL_EN
      acc    <= '0;
      idx    <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op_in;
            rx_q <= rx_in;
            ry_q <= ry_in;
            if (!op_legal(op_in)) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (op_in == OP_LOAD) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= data_in;
`ifdef ALU_SEQ_MINALL_EN
            end else if (op_in == OP_MINALL) begin
              acc   <= ra_data;
              idx   <= AW'(1);
              state <= S_LOOP;
`endif
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result <= alu_out;
          done   <= 1'b1;
          state  <= S_DONE;
        end
`ifdef ALU_SEQ_MINALL_EN
        S_LOOP: begin
          acc <= alu_out;
          idx <= idx + 1'b1;
          // NREG is a power of two, so the last index is all ones
          if (idx == '1) begin
            result <= alu_out;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and
// register-bank reference model; follows ALU_SEQ_MINALL_EN if defined.
module tb_alu_sequencer;

  localparam int NREG = 8;
`ifdef ALU_SEQ_MINALL_EN
  localparam bit MINALL_ON = 1'b1;
  localparam int RST_MID   = 3;
  localparam logic [3:0] RST_OP = 4'b0111;
`else
  localparam bit MINALL_ON = 1'b0;
  localparam int RST_MID   = 0;
  localparam logic [3:0] RST_OP = 4'b0010;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] data_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  ins;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] alu_out;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [3:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mdl [NREG];
  logic [15:0] mres;

  always #5 clk = ~clk;

  alu_sequencer #(.NREG(NREG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .data_in     (data_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ins         (ins),
    .a_in        (a_in),
    .b_in        (b_in),
    .alu_out     (alu_out),
    .done        (done),
    .err         (err),
    .result      (result),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // external ALU the sequencer is wired to
  always_comb begin
    alu_out = '0;
    case (ins)
      4'b0010: alu_out = a_in + b_in;
      4'b0011: alu_out = a_in ^ b_in;
      4'b0100, 4'b0111: alu_out = (a_in < b_in) ? a_in : b_in;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = {1'($urandom), 3'(i)};
      #1;
      check(tag, dbg_data, mdl[i]);
    end
  endtask

  function automatic logic [15:0] min_all();
    logic [15:0] m;
    m = mdl[0];
    foreach (mdl[i]) if (mdl[i] < m) m = mdl[i];
    return m;
  endfunction

  function automatic logic [15:0] mk_instr(input logic [3:0] op,
                                           input int rx, input int ry);
    return {op, 1'($urandom), 3'(rx), 1'($urandom), 3'(ry),
            4'($urandom)};
  endfunction

  // Called just after a clock edge with the DUT idle or finishing.
  task automatic issue(input logic [3:0] op, input int rx, input int ry,
                       input logic [15:0] d);
    logic [15:0] ra, rb, nv;
    logic [3:0]  busy_ins;
    bit          legal, ok;
    int          lat, want;
    ra = mdl[rx];
    rb = mdl[ry];
    legal = (op inside {4'd1, 4'd2, 4'd3, 4'd4}) ||
            (op == 4'd7 && MINALL_ON);
    case (op)
      4'd1: nv = d;
      4'd2: nv = ra + rb;
      4'd3: nv = ra ^ rb;
      4'd4: nv = (ra < rb) ? ra : rb;
      4'd7: nv = min_all();
      default: nv = ra;
    endcase
    if (!legal || op == 4'd1) want = 1;
    else if (op == 4'd7) want = NREG;
    else want = 2;
    busy_ins = op;

    instr = mk_instr(op, rx, ry);
    data_in = d;
    instr_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (instr_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("ready_idle", 16'(ok), 16'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    data_in = 16'($urandom);

    lat = 1;
    while (!done && lat <= NREG + 2) begin
      check("ins_busy", {12'h0, ins}, {12'h0, busy_ins});
      check("ready_busy", 16'(instr_ready), 16'd0);
      if (lat == 1 && op != 4'd7) begin
        check("a_in", a_in, ra);
        check("b_in", b_in, rb);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 16'(lat), 16'(want));
    check("done", 16'(done), 16'd1);
    check("err", 16'(err), 16'(!legal));
    if (legal) begin
      mdl[rx] = nv;
      mres = nv;
    end
    check("result", result, mres);
    check("ins_done", {12'h0, ins}, 16'h0);
    check("ready_done", 16'(instr_ready), 16'd0);
    check_regs("regs");
    @(posedge clk); #1;
    check("done_pulse", 16'(done), 16'd0);
  endtask

  initial begin
    int pulses;
    logic [3:0] op;
    logic [15:0] vals [NREG];
    vals = '{16'd9, 16'd7, 16'd8, 16'hFFFF, 16'd3, 16'd6, 16'd5, 16'd4};

    foreach (mdl[i]) mdl[i] = '0;
    mres = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 16'(done), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_result", result, 16'h0);
    check("rst_ins", {12'h0, ins}, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 16'(instr_ready), 16'd1);
    check_regs("rst_regs");

    issue(4'd1, 1, 0, 16'h0005);
    issue(4'd1, 2, 0, 16'h0003);

    issue(4'd1, 1, 0, 16'hFFFF);
    issue(4'd1, 2, 0, 16'h0002);
    issue(4'd2, 1, 2, 16'h0000);

    issue(4'd1, 3, 0, 16'hA5A5);
    issue(4'd3, 3, 3, 16'h0000);
    issue(4'd1, 1, 0, 16'h0009);
    issue(4'd1, 2, 0, 16'h0004);
    issue(4'd4, 1, 2, 16'h0000);

    for (int i = 0; i < NREG; i++) issue(4'd1, i, 0, vals[i]);
    issue(4'd7, 0, 0, 16'h0000);

    issue(4'hF, 2, 3, 16'h1234);

    // illegal op with valid held: next op waits for the cycle after done
    instr = mk_instr(4'hF, 4, 4);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_done", 16'(done), 16'd1);
    check("b2b_err", 16'(err), 16'd1);
    check("b2b_result", result, mres);
    check("b2b_ready", 16'(instr_ready), 16'd0);
    instr = mk_instr(4'd1, 5, 0);
    data_in = 16'hBEEF;
    @(posedge clk); #1;
    check("b2b_gap_done", 16'(done), 16'd0);
    check("b2b_gap_ready", 16'(instr_ready), 16'd1);
    check_regs("b2b_gap_regs");
    @(posedge clk); #1;
    instr_valid = 1'b0;
    mdl[5] = 16'hBEEF;
    mres = 16'hBEEF;
    check("b2b_second_done", 16'(done), 16'd1);
    check("b2b_second_err", 16'(err), 16'd0);
    check("b2b_second_result", result, mres);
    check_regs("b2b_regs");
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd3;
        4: op = 4'd4;
        default: op = ($urandom_range(0, 1) == 0) ? 4'd7
                                                  : 4'($urandom);
      endcase
      issue(op, int'($urandom_range(0, NREG - 1)),
            int'($urandom_range(0, NREG - 1)), 16'($urandom));
    end

    // reset while a multi-cycle op is in flight
    instr = mk_instr(RST_OP, 0, 1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (RST_MID) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    foreach (mdl[i]) mdl[i] = '0;
    mres = '0;
    check("mid_rst_done", 16'(done), 16'd0);
    check("mid_rst_err", 16'(err), 16'd0);
    check("mid_rst_result", result, 16'h0);
    check("mid_rst_ins", {12'h0, ins}, 16'h0);
    check("mid_rst_a", a_in, 16'h0);
    check("mid_rst_b", b_in, 16'h0);
    check_regs("mid_rst_regs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", 16'(instr_ready), 16'd1);
    pulses = 0;
    for (int k = 0; k < NREG + 2; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("mid_rst_no_done", 16'(pulses), 16'd0);
    issue(4'd1, 6, 0, 16'h00AA);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
